// File: rtl/pipeline_preload_sequencer_pkg.sv
// Shared pipeline header: FSM state encodings and the word-count width rule,
// also used by the future drain/readback block.
package pipeline_preload_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FIRE = 2'd2
  } pipe_state_e;

  // Count must reach NUMBER_OF_STAGES, and is never narrower than one bit.
  function automatic int pipe_cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipeline_preload_sequencer.sv
// Collects NUMBER_OF_STAGES words over valid/ready into a packed preload vector,
// then fires a one-cycle set strobe so the downstream chain loads atomically.
module pipeline_preload_sequencer
  import pipeline_preload_sequencer_pkg::*;
#(
  parameter int BIT_WIDTH        = 10,
  parameter int NUMBER_OF_STAGES = 5
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic                                  in_valid,
  input  logic [BIT_WIDTH-1:0]                  in_data,
  output logic                                  in_ready,
  output logic                                  set,
  output logic [BIT_WIDTH*NUMBER_OF_STAGES-1:0] set_data,
  output logic                                  busy,
  output logic                                  done
);

  if (NUMBER_OF_STAGES < 1) begin : g_bad_stages
    $error("pipeline_preload_sequencer: NUMBER_OF_STAGES must be >= 1");
  end

  localparam int            CW       = pipe_cnt_width(NUMBER_OF_STAGES);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUMBER_OF_STAGES - 1);

  pipe_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          in_ready_q;
  logic          set_q;
  logic          done_q;
  logic          busy_q;

  logic xfer;
  logic take;
  logic clear;

  assign xfer  = in_valid && in_ready_q;
  // abort beats a coincident transfer: the word is neither stored nor counted
  assign take  = xfer && !abort;
  assign clear = (state_q == IDLE) && start;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      set_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      set_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        FILL: begin
          if (abort) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (xfer) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST_IDX) begin
              state_q    <= FIRE;
              in_ready_q <= 1'b0;
              set_q      <= 1'b1;
              done_q     <= 1'b1;
            end
          end
        end
        FIRE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Slice s receives word index N-1-s, so word 0 sits in the top slice.
  for (genvar s = 0; s < NUMBER_OF_STAGES; s++) begin : g_slice
    localparam logic [CW-1:0] WORD_IDX = CW'(NUMBER_OF_STAGES - 1 - s);

    logic [BIT_WIDTH-1:0] slice_q;
    logic [BIT_WIDTH-1:0] slice_d;

    always_comb begin
      slice_d = slice_q;
      if (clear) begin
        slice_d = '0;
      end else if (take && (cnt_q == WORD_IDX)) begin
        slice_d = in_data;
      end
    end

    // NOTE: the preload storage is reset like any control flop because
    // set_data is a visible output with a defined reset value of zero.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        slice_q <= '0;
      end else begin
        slice_q <= slice_d;
      end
    end

    assign set_data[BIT_WIDTH*s +: BIT_WIDTH] = slice_q;
  end

  assign in_ready = in_ready_q;
  assign set      = set_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pipeline_preload_sequencer.sv
// Self-checking bench: table vectors, hand sequences for corner cases, and
// randomized traffic against a word-queue reference model.
module tb_pipeline_preload_sequencer;

  localparam int BW = 10;
  localparam int N  = 5;
  localparam int VW = BW * N;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic [BW-1:0] in_data;
  logic          in_ready;
  logic          set;
  logic [VW-1:0] set_data;
  logic          busy;
  logic          done;

  logic          u1_start;
  logic          u1_abort;
  logic          u1_in_valid;
  logic [BW-1:0] u1_in_data;
  logic          u1_in_ready;
  logic          u1_set;
  logic [BW-1:0] u1_set_data;
  logic          u1_busy;
  logic          u1_done;

  int total = 0;
  int bad   = 0;

  pipeline_preload_sequencer #(.BIT_WIDTH(BW), .NUMBER_OF_STAGES(N)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .set      (set),
    .set_data (set_data),
    .busy     (busy),
    .done     (done)
  );

  pipeline_preload_sequencer #(.BIT_WIDTH(BW), .NUMBER_OF_STAGES(1)) dut1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (u1_start),
    .abort    (u1_abort),
    .in_valid (u1_in_valid),
    .in_data  (u1_in_data),
    .in_ready (u1_in_ready),
    .set      (u1_set),
    .set_data (u1_set_data),
    .busy     (u1_busy),
    .done     (u1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the list of words accepted since the last start, plus
  // whether a fill is open and whether this is the strobe cycle.
  bit            m_filling;
  bit            m_firing;
  int            m_got;
  logic [BW-1:0] m_words [N];

  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < m_got; i++) v[BW*(N-i)-1 -: BW] = m_words[i];
    return v;
  endfunction

  task automatic model_reset();
    m_filling = 1'b0;
    m_firing  = 1'b0;
    m_got     = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the edge, then compare #1 later.
  task automatic step();
    @(posedge clk);
    if (m_firing) begin
      m_firing = 1'b0;
    end else if (m_filling) begin
      if (abort) begin
        m_filling = 1'b0;
      end else if (in_valid) begin
        m_words[m_got] = in_data;
        m_got++;
        if (m_got == N) begin
          m_filling = 1'b0;
          m_firing  = 1'b1;
        end
      end
    end else if (start) begin
      m_filling = 1'b1;
      m_got     = 0;
    end
    #1;
    check("model in_ready", 64'(in_ready), 64'(m_filling));
    check("model set",      64'(set),      64'(m_firing));
    check("model done",     64'(done),     64'(m_firing));
    check("model busy",     64'(busy),     64'(m_filling | m_firing));
    check("model set_data", 64'(set_data), 64'(model_vec()));
  endtask

  task automatic drive(input logic st, input logic ab, input logic v, input logic [BW-1:0] d);
    start    = st;
    abort    = ab;
    in_valid = v;
    in_data  = d;
  endtask

  typedef struct {
    logic          st;
    logic          ab;
    logic          v;
    logic [BW-1:0] d;
    logic          e_rdy;
    logic          e_set;
    logic          e_busy;
    logic          chk_vec;
    logic [VW-1:0] e_vec;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic v, input logic [BW-1:0] d,
                              input logic e_rdy, input logic e_set, input logic e_busy,
                              input logic chk_vec, input logic [VW-1:0] e_vec);
    vec_t r;
    r.st = st; r.ab = 1'b0; r.v = v; r.d = d;
    r.e_rdy = e_rdy; r.e_set = e_set; r.e_busy = e_busy;
    r.chk_vec = chk_vec; r.e_vec = e_vec;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [VW-1:0] full_vec;
    logic [VW-1:0] stall_vec;
    logic [VW-1:0] part_vec;
    logic [VW-1:0] re_vec;
    logic [VW-1:0] b2b_vec;
    int            set_seen;

    full_vec  = {10'h001, 10'h002, 10'h003, 10'h004, 10'h005};
    stall_vec = {10'h011, 10'h012, 10'h013, 10'h014, 10'h015};
    part_vec  = {10'h021, 10'h022, 30'h0};
    re_vec    = {10'h031, 10'h032, 10'h033, 10'h034, 10'h035};
    b2b_vec   = {10'h041, 10'h042, 10'h043, 10'h044, 10'h045};

    // Full load: five consecutive words, strobe one cycle after the fifth.
    tbl.push_back(mk(1, 0, 10'h000, 1, 0, 1, 1, '0));
    for (int k = 1; k <= 4; k++) tbl.push_back(mk(0, 1, BW'(k), 1, 0, 1, 0, '0));
    tbl.push_back(mk(0, 1, 10'h005, 0, 1, 1, 1, full_vec));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 1, full_vec));
    // Stalls: valid toggles, garbage data on idle beats must be ignored.
    tbl.push_back(mk(1, 0, 10'h000, 1, 0, 1, 1, '0));
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(mk(0, 1, BW'(16'h11 + k), 1, 0, 1, 0, '0));
      tbl.push_back(mk(0, 0, 10'h3AA,         1, 0, 1, 0, '0));
    end
    tbl.push_back(mk(0, 1, 10'h015, 0, 1, 1, 1, stall_vec));
    tbl.push_back(mk(0, 0, 10'h000, 0, 0, 0, 1, stall_vec));

    model_reset();
    drive(0, 0, 0, '0);
    u1_start = 1'b0; u1_abort = 1'b0; u1_in_valid = 1'b0; u1_in_data = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset set",      64'(set),      64'd0);
    check("reset set_data", 64'(set_data), 64'd0);
    check("reset busy",     64'(busy),     64'd0);
    check("reset done",     64'(done),     64'd0);

    // Reset mid-fill clears every output asynchronously.
    drive(1, 0, 0, '0);        step();
    drive(0, 0, 1, 10'h0AA);   step();
    drive(0, 0, 1, 10'h0BB);   step();
    drive(0, 0, 0, '0);
    check("midfill busy before reset", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async in_ready", 64'(in_ready), 64'd0);
    check("async busy",     64'(busy),     64'd0);
    check("async set_data", 64'(set_data), 64'd0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    check("post-reset in_ready", 64'(in_ready), 64'd0);

    foreach (tbl[i]) begin
      start    = tbl[i].st;
      abort    = tbl[i].ab;
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      step();
      check($sformatf("tbl[%0d] in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
      check($sformatf("tbl[%0d] set", i),      64'(set),      64'(tbl[i].e_set));
      check($sformatf("tbl[%0d] done", i),     64'(done),     64'(tbl[i].e_set));
      check($sformatf("tbl[%0d] busy", i),     64'(busy),     64'(tbl[i].e_busy));
      if (tbl[i].chk_vec) check($sformatf("tbl[%0d] set_data", i), 64'(set_data), 64'(tbl[i].e_vec));
    end

    // Abort colliding with the third transfer: no strobe, partial vector kept.
    drive(1, 0, 0, '0);       step();
    check("start clears set_data", 64'(set_data), 64'd0);
    drive(0, 0, 1, 10'h021);  step();
    drive(0, 0, 1, 10'h022);  step();
    drive(0, 1, 1, 10'h023);  step();
    check("abort set",      64'(set),      64'd0);
    check("abort busy",     64'(busy),     64'd0);
    check("abort in_ready", 64'(in_ready), 64'd0);
    check("abort partial",  64'(set_data), 64'(part_vec));
    drive(0, 1, 0, '0);       step();
    check("abort in idle ignored", 64'(busy), 64'd0);
    drive(1, 1, 0, '0);       step();
    check("start beats abort", 64'(in_ready), 64'd1);
    for (int k = 0; k < N; k++) begin
      drive(0, 0, 1, BW'(16'h31 + k));
      step();
    end
    check("refill set",      64'(set),      64'd1);
    check("refill set_data", 64'(set_data), 64'(re_vec));

    // start held high through FILL/FIRE, then accepted right after FIRE.
    drive(0, 0, 0, '0);       step();
    drive(1, 0, 0, '0);       step();
    for (int k = 0; k < N; k++) begin
      drive(1, 0, 1, BW'(16'h41 + k));
      step();
    end
    check("b2b first set",  64'(set),      64'd1);
    check("b2b first vec",  64'(set_data), 64'(b2b_vec));
    drive(1, 0, 0, '0);       step();
    check("b2b idle ready", 64'(in_ready), 64'd0);
    drive(1, 0, 0, '0);       step();
    check("b2b restart ready", 64'(in_ready), 64'd1);
    set_seen = 0;
    for (int k = 0; k < N; k++) begin
      drive(0, 0, 1, BW'(16'h51 + k));
      step();
      if (set) set_seen = k + 1;
    end
    check("b2b second set position", 64'(set_seen), 64'(N));
    drive(0, 0, 0, '0);       step();

    // Single-stage instance.
    u1_start = 1'b1;          step();
    check("n1 in_ready", 64'(u1_in_ready), 64'd1);
    u1_start = 1'b0; u1_in_valid = 1'b1; u1_in_data = 10'h3FF; step();
    check("n1 set",      64'(u1_set),      64'd1);
    check("n1 done",     64'(u1_done),     64'd1);
    check("n1 set_data", 64'(u1_set_data), 64'h3FF);
    u1_in_valid = 1'b0; u1_in_data = '0; step();
    check("n1 busy after", 64'(u1_busy),   64'd0);
    check("n1 set after",  64'(u1_set),    64'd0);
    check("n1 hold data",  64'(u1_set_data), 64'h3FF);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      drive(($urandom_range(3) == 0), ($urandom_range(15) == 0),
            ($urandom_range(1) == 1), BW'($urandom));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
